// File: rtl/id_ex_elastic_reg.sv
// ID/EX elastic pipeline register: a main entry plus a skid entry behind a
// valid/ready handshake, with flush, optional bubble zeroing and a stall counter.
module id_ex_elastic_reg #(
    parameter int CTRL_W      = 22,
    parameter int DATA_W      = 32,
    parameter int NUM_DATA    = 3,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [1:0]                 occupancy,
    input  logic                       clr_stats,
    output logic [CNT_W-1:0]           stall_count
);

    localparam int   PAY_W   = CTRL_W + NUM_DATA * DATA_W;
    localparam logic ZB      = (ZERO_BUBBLE != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    state_t             state_r;
    state_t             state_n_s;
    logic               out_valid_r;
    logic               in_ready_r;
    logic [PAY_W-1:0]   main_pay_r;
    logic [PAY_W-1:0]   skid_pay_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [PAY_W-1:0]   in_pay_s;

    logic accept_s;
    logic fire_s;
    logic load_main_in_s;
    logic load_main_skid_s;
    logic load_skid_s;
    logic clr_main_s;
    logic clr_skid_s;

    assign in_pay_s = {in_ctrl, in_data};

    // Next-state and datapath steering; flush overrides every transition.
    always_comb begin
        state_n_s        = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        clr_main_s       = 1'b0;
        clr_skid_s       = 1'b0;
        accept_s         = in_valid & in_ready_r;
        fire_s           = out_valid_r & out_ready;
        if (flush) begin
            state_n_s  = ST_EMPTY;
            clr_main_s = ZB;
            clr_skid_s = ZB;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        load_main_in_s = 1'b1;
                        state_n_s      = ST_ONE;
                    end else begin
                        state_n_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (fire_s && accept_s) begin
                        load_main_in_s = 1'b1;
                        state_n_s      = ST_ONE;
                    end else if (fire_s) begin
                        clr_main_s = ZB;
                        state_n_s  = ST_EMPTY;
                    end else if (accept_s) begin
                        load_skid_s = 1'b1;
                        state_n_s   = ST_FULL;
                    end else begin
                        state_n_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (fire_s) begin
                        load_main_skid_s = 1'b1;
                        clr_skid_s       = ZB;
                        state_n_s        = ST_ONE;
                    end else begin
                        state_n_s = ST_FULL;
                    end
                end
                default: begin
                    state_n_s  = ST_EMPTY;
                    clr_main_s = 1'b1;
                    clr_skid_s = 1'b1;
                end
            endcase
        end
    end

    // State plus the handshake flags, registered from the next state so in_ready
    // never sees out_ready or flush combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_n_s;
            out_valid_r <= (state_n_s != ST_EMPTY);
            in_ready_r  <= (state_n_s != ST_FULL);
        end
    end

    // Main entry payload: fresh input, promoted skid word, or bubble zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_pay_r <= '0;
        end else if (load_main_in_s) begin
            main_pay_r <= in_pay_s;
        end else if (load_main_skid_s) begin
            main_pay_r <= skid_pay_r;
        end else if (clr_main_s) begin
            main_pay_r <= '0;
        end else begin
            main_pay_r <= main_pay_r;
        end
    end

    // Skid entry payload, captured only when main is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_pay_r <= '0;
        end else if (load_skid_s) begin
            skid_pay_r <= in_pay_s;
        end else if (clr_skid_s) begin
            skid_pay_r <= '0;
        end else begin
            skid_pay_r <= skid_pay_r;
        end
    end

    // Saturating stall counter; clear wins over increment, flush is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= '0;
        end else if (clr_stats) begin
            stall_cnt_r <= '0;
        end else if (out_valid_r && !out_ready) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_ctrl    = main_pay_r[PAY_W-1 -: CTRL_W];
    assign out_data    = main_pay_r[NUM_DATA*DATA_W-1:0];
    assign occupancy   = state_r;
    assign stall_count = stall_cnt_r;

endmodule

// File: doc/id_ex_elastic_reg.md
# id_ex_elastic_reg

Parametrised, elastic successor to the fixed-width ID/EX control register. It carries the decode-stage control word plus a configurable number of operand/data fields into EX through a two-entry valid/ready buffer (main + skid). It supports hazard stalls through backpressure, synchronous flush for branch squash, optional bubble zeroing and a saturating stall counter. It sits between the decode logic and the EX stage; a chain of these forms the pipeline spine.

## Interface
- CTRL_W, 22, control-word width (ALU op, branch, load, RF enable, operand-source, TA bits).
- DATA_W, 32, width of one data field.
- NUM_DATA, 3, number of data fields (e.g. rs value, rt value, immediate); payload width = NUM_DATA*DATA_W.
- ZERO_BUBBLE, 1, 1: out_ctrl/out_data driven to 0 whenever out_valid=0; 0: they hold the last presented values.
- CNT_W, 16, stall-counter width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- in_valid  in  1  decode has a word to transfer.
- in_ready  out  1  stage can accept; equals NOT skid_valid (register-derived, no combinational path from out_ready).
- in_ctrl  in  CTRL_W  control word.
- in_data  in  NUM_DATA*DATA_W  packed data fields, field k at [k*DATA_W +: DATA_W].
- flush  in  1  synchronous squash of all held entries and any same-cycle input.
- out_valid  out  1  main entry valid.
- out_ready  in  1  EX accepts this cycle.
- out_ctrl  out  CTRL_W  main-entry control word.
- out_data  out  NUM_DATA*DATA_W  main-entry data.
- occupancy  out  2  entries held: 0, 1 or 2.
- clr_stats  in  1  synchronous clear of stall_count.
- stall_count  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept = in_valid & in_ready. Fire = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
- EMPTY: accept -> load main, go to ONE.
- ONE: fire & accept -> main reloads from input, stay in ONE. Fire only -> EMPTY. Accept only -> input goes to skid, FULL. Neither -> hold.
- FULL: in_ready=0. Fire -> main loads from skid, skid clears, ONE. No fire -> hold.
- Flush (highest priority below reset): next state EMPTY, both valids cleared, same-cycle input dropped, and an output fire in that cycle is still counted as consumed by EX. Data registers are zeroed if ZERO_BUBBLE=1.
- FIFO order is strictly preserved; no entry is duplicated or dropped except by flush.
- stall_count: +1 per cycle with out_valid & ~out_ready. Saturates at 2^CNT_W-1. clr_stats takes precedence over increment. The counter is not affected by flush.
- Reset values: out_valid=0, occupancy=0, in_ready=1, out_ctrl=0, out_data=0, stall_count=0, skid contents 0.

## Timing
- Latency: an accept at edge N gives out_valid=1 with that word after edge N when the stage was EMPTY, or after a same-cycle fire in ONE.
- Throughput: one word per cycle with out_ready held high.
- in_ready falls the cycle after the skid is filled and rises the cycle after the skid drains. in_ready never depends combinationally on out_ready or flush.
- Reset asserted mid-operation clears immediately, without waiting for clk. Deassertion is synchronised externally; the first accept can occur on the first edge after release.
- occupancy and stall_count are registered and update on the same edge as the state.

## Test plan
- Reset: hold reset low with random inputs -> out_valid=0, in_ready=1, occupancy=0, out_ctrl=0, stall_count=0. Release, then send ctrl=22'h15A5A5 -> it appears one cycle later.
- Streaming: out_ready=1, four back-to-back words with ctrl 1,2,3,4 -> out_ctrl 1,2,3,4 on consecutive cycles, occupancy never above 1.
- Backpressure: out_ready=0 for 3 cycles while sending words A,B,C -> A and B are accepted, in_ready=0 from the cycle after B, C is held by the source, stall_count=3. Raise out_ready -> output order A,B,C with no gaps.
- Flush in FULL with in_valid=1 (word D) -> next cycle occupancy=0, out_valid=0, out_ctrl=0 and out_data=0 (ZERO_BUBBLE=1). D never appears.
- Saturation, CNT_W=4: 20 stalled cycles -> stall_count=15. Pulse clr_stats while still stalled -> 0 on the next cycle, then counting resumes.
- Async reset pulsed low between edges while FULL -> outputs clear before the next clk edge. The stage then resumes cleanly with new words.
